// File: rtl/crc32_feeder_pkg.sv
// crc32_feeder_pkg: shared types and constants for the CRC32 bus-master feeder.
// Holds the CRC peripheral register map, the FSM state enum, the CONF register
// bit positions and the FIFO entry layout.
// Optional feature macro: CRC_FEED_COUNT_EN (adds the length read-back).

`ifndef CRC32_PERIPH_ADR_DEFS
`define CRC32_PERIPH_ADR_DEFS
`define CRC_DATA_ADR  8'h10
`define CRC_CONF_ADR  8'h14
`define CRC_OUT_ADR   8'h18
`define CRC_COUNT_ADR 8'h1C
`endif

package crc32_feeder_pkg;

  // Peripheral register map, taken from the shared address defines.
  localparam logic [7:0] CRC_DATA_ADR_C  = `CRC_DATA_ADR;
  localparam logic [7:0] CRC_CONF_ADR_C  = `CRC_CONF_ADR;
  localparam logic [7:0] CRC_OUT_ADR_C   = `CRC_OUT_ADR;
  localparam logic [7:0] CRC_COUNT_ADR_C = `CRC_COUNT_ADR;

  // CONF register fields.
  localparam int CONF_POLY_BIT    = 0;
  localparam int CONF_RST_LGT_BIT = 1;

  // Bus sequencer states. GAP is shared by every access; the state that
  // preceded it decides where GAP goes next.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CONF   = 3'd1,
    ST_DATA   = 3'd2,
    ST_GAP    = 3'd3,
    ST_RD_CRC = 3'd4,
    ST_RD_CNT = 3'd5,
    ST_RES    = 3'd6
  } state_e;

  // One buffered stream word.
  typedef struct packed {
    logic        poly;
    logic        last;
    logic [31:0] data;
  } fifo_entry_t;

  localparam int ENTRY_W = $bits(fifo_entry_t);

  // CONF write value: always clear the length counter and CRC state.
  function automatic logic [31:0] conf_word(input logic poly);
    logic [31:0] w;
    w                   = '0;
    w[CONF_RST_LGT_BIT] = 1'b1;
    w[CONF_POLY_BIT]    = poly;
    return w;
  endfunction

endpackage

// File: rtl/crc32_feeder_fifo.sv
// crc32_feeder_fifo: synchronous FIFO with full/empty flags.
// Head word is presented combinationally (show-ahead). Pushes into a full FIFO
// and pops from an empty one are ignored.

module crc32_feeder_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 34
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Storage array; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

  // Read/write pointers; reset flushes the FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/crc32_feeder.sv
// crc32_feeder: buffers framed stream words and drives the CRC32 peripheral
// bus (CONF write, DATA writes, result reads), then offers the frame CRC on a
// result port.
// Optional feature macro: CRC_FEED_COUNT_EN -- when defined the frame length
// is read back from CRC_COUNT_ADR into res_count_o; otherwise res_count_o is 0.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both high. The source holds valid and its payload stable until that edge;
// ready may depend combinationally only on the receiver's own state (here
// s_ready_o comes from the FIFO fill level alone, never from s_valid_i), and
// res_* stay stable while res_valid_o is high and res_ready_i is low.

module crc32_feeder
  import crc32_feeder_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADR_W      = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      s_data_i,
  input  logic             s_last_i,
  input  logic             s_poly_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  output logic [ADR_W-1:0] pr_adr_o,
  output logic             edwr_l_o,
  output logic             edwr_h_o,
  output logic             sedrd_o,
  output logic [31:0]      src_o,
  input  logic [31:0]      pr_src_i,
  output logic [31:0]      res_crc_o,
  output logic [31:0]      res_count_o,
  output logic             res_valid_o,
  input  logic             res_ready_i
);

  localparam logic [ADR_W-1:0] ADR_DATA  = ADR_W'(CRC_DATA_ADR_C);
  localparam logic [ADR_W-1:0] ADR_CONF  = ADR_W'(CRC_CONF_ADR_C);
  localparam logic [ADR_W-1:0] ADR_OUT   = ADR_W'(CRC_OUT_ADR_C);
`ifdef CRC_FEED_COUNT_EN
  localparam logic [ADR_W-1:0] ADR_COUNT = ADR_W'(CRC_COUNT_ADR_C);
`endif

  state_e             state_q;
  state_e             state_d;
  state_e             after_q;        // access that the current GAP follows
  logic               last_q;         // last flag of the most recently popped word
  logic               frame_start_q;  // head of FIFO begins a new frame
  logic               push_start_q;   // next pushed word begins a new frame

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  fifo_entry_t        wr_entry;
  logic [ENTRY_W-1:0] head_bits;
  fifo_entry_t        head;
  logic [31:0]        res_crc_q;

  assign s_ready_o   = !fifo_full;
  assign fifo_push   = s_valid_i && s_ready_o;
  assign fifo_pop    = (state_q == ST_DATA);
  assign head        = fifo_entry_t'(head_bits);
  assign res_valid_o = (state_q == ST_RES);
  assign res_crc_o   = res_crc_q;

  // Poly is only meaningful on a frame's first word; mask it elsewhere.
  assign wr_entry.poly = s_poly_i && push_start_q;
  assign wr_entry.last = s_last_i;
  assign wr_entry.data = s_data_i;

  crc32_feeder_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .wdata_i (wr_entry),
    .pop_i   (fifo_pop),
    .rdata_o (head_bits),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Next-state logic. IDLE also reacts to a push in the same cycle so the
  // first strobe follows the push edge directly.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty || fifo_push) begin
          state_d = frame_start_q ? ST_CONF : ST_DATA;
        end
      end
      ST_CONF, ST_DATA, ST_RD_CRC: state_d = ST_GAP;
`ifdef CRC_FEED_COUNT_EN
      ST_RD_CNT: state_d = ST_GAP;
`endif
      ST_GAP: begin
        case (after_q)
          ST_CONF: state_d = ST_DATA;
          ST_DATA: begin
            if (last_q)           state_d = ST_RD_CRC;
            else if (!fifo_empty) state_d = ST_DATA;
            else                  state_d = ST_IDLE;
          end
`ifdef CRC_FEED_COUNT_EN
          ST_RD_CRC: state_d = ST_RD_CNT;
          ST_RD_CNT: state_d = ST_RES;
`else
          ST_RD_CRC: state_d = ST_RES;
`endif
          default:   state_d = ST_IDLE;
        endcase
      end
      ST_RES: if (res_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state, GAP context and frame-boundary tracking.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      after_q       <= ST_IDLE;
      last_q        <= 1'b0;
      frame_start_q <= 1'b1;
      push_start_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      if (state_d == ST_GAP) after_q <= state_q;
      if (fifo_pop) begin
        last_q        <= head.last;
        frame_start_q <= head.last;
      end
      if (fifo_push) push_start_q <= s_last_i;
    end
  end

  // Peripheral read data is registered, so capture it at the end of the GAP.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_crc_q <= '0;
    end else if (state_q == ST_GAP && after_q == ST_RD_CRC) begin
      res_crc_q <= pr_src_i;
    end
  end

`ifdef CRC_FEED_COUNT_EN
  logic [31:0] res_count_q;

  // Frame length read back from the peripheral.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_count_q <= '0;
    end else if (state_q == ST_GAP && after_q == ST_RD_CNT) begin
      res_count_q <= pr_src_i;
    end
  end

  assign res_count_o = res_count_q;
`else
  assign res_count_o = 32'd0;
`endif

  // Bus drive decoded from the current state; every non-access cycle is idle.
  always_comb begin
    pr_adr_o = '0;
    edwr_l_o = 1'b1;
    edwr_h_o = 1'b1;
    sedrd_o  = 1'b1;
    src_o    = '0;
    case (state_q)
      ST_CONF: begin
        pr_adr_o = ADR_CONF;
        edwr_l_o = 1'b0;
        edwr_h_o = 1'b0;
        src_o    = conf_word(head.poly);
      end
      ST_DATA: begin
        pr_adr_o = ADR_DATA;
        edwr_l_o = 1'b0;
        edwr_h_o = 1'b0;
        src_o    = head.data;
      end
      ST_RD_CRC: begin
        pr_adr_o = ADR_OUT;
        sedrd_o  = 1'b0;
      end
`ifdef CRC_FEED_COUNT_EN
      ST_RD_CNT: begin
        pr_adr_o = ADR_COUNT;
        sedrd_o  = 1'b0;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_crc32_feeder.sv
// tb_crc32_feeder: self-checking bench for crc32_feeder.
// Honours CRC_FEED_COUNT_EN the same way as the design.

module tb_crc32_feeder;
  import crc32_feeder_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 8;
  localparam int W     = 42;  // {rd, wr, adr[7:0], data[31:0]}
`ifdef CRC_FEED_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  localparam logic [AW-1:0] A_DATA = CRC_DATA_ADR_C;
  localparam logic [AW-1:0] A_CONF = CRC_CONF_ADR_C;
  localparam logic [AW-1:0] A_OUT  = CRC_OUT_ADR_C;
  localparam logic [AW-1:0] A_CNT  = CRC_COUNT_ADR_C;
  localparam logic [31:0]   CRC_V  = 32'hDEADBEEF;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic [31:0]   s_data_i = '0;
  logic          s_last_i = 1'b0;
  logic          s_poly_i = 1'b0;
  logic          s_valid_i = 1'b0;
  logic          s_ready_o;
  logic [AW-1:0] pr_adr_o;
  logic          edwr_l_o, edwr_h_o, sedrd_o;
  logic [31:0]   src_o;
  logic [31:0]   pr_src_i = '0;
  logic [31:0]   res_crc_o, res_count_o;
  logic          res_valid_o;
  logic          res_ready_i = 1'b0;

  always #5 clk = ~clk;

  crc32_feeder #(.FIFO_DEPTH(DEPTH), .ADR_W(AW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .s_data_i(s_data_i), .s_last_i(s_last_i), .s_poly_i(s_poly_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .pr_adr_o(pr_adr_o), .edwr_l_o(edwr_l_o), .edwr_h_o(edwr_h_o),
    .sedrd_o(sedrd_o), .src_o(src_o), .pr_src_i(pr_src_i),
    .res_crc_o(res_crc_o), .res_count_o(res_count_o),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- counters and check helper ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- peripheral model ----------------
  // Registered reads: value appears the cycle after the read strobe, junk otherwise.
  int unsigned per_cnt = 0;
  bit          rd_pend = 1'b0;
  logic [31:0] rd_val  = '0;

  always @(negedge clk) begin
    rd_pend = 1'b0;
    if (!edwr_l_o && pr_adr_o == A_CONF && src_o[CONF_RST_LGT_BIT]) per_cnt = 0;
    if (!edwr_l_o && !edwr_h_o && pr_adr_o == A_DATA) per_cnt++;
    if (!sedrd_o) begin
      rd_pend = 1'b1;
      rd_val  = (pr_adr_o == A_OUT) ? CRC_V : (pr_adr_o == A_CNT) ? 32'(per_cnt) : 32'h0;
    end
  end

  always @(posedge clk) pr_src_i <= rd_pend ? rd_val : $urandom;

  // ---------------- res_ready driver ----------------
  bit rr_rand = 1'b0;
  bit rr_val  = 1'b1;
  always @(posedge clk) begin
    #1;
    res_ready_i = rr_rand ? 1'($urandom_range(0, 1)) : rr_val;
  end

  // ---------------- scoreboard / compare process ----------------
  logic [W-1:0] exp_q[$];
  logic [63:0]  res_q[$];
  int           occ = 0;
  bit           tx_first = 1'b1;
  int           tx_len = 0;
  bit           prev_strobe = 1'b0;
  bit           prev_valid = 1'b0;
  bit           chk_rst = 1'b0;
  int           frames_read = 0;
  int           frames_hs = 0;
  int           dw_cnt = 0;
  int           conf_cyc = 0;
  int           lat_n = 0;
  bit           fs_arm = 1'b0;
  int           fs_acc = -1;
  logic [31:0]  last_conf = '0;
  logic [31:0]  last_crc = '0;
  logic [31:0]  last_cnt = '0;

  function automatic logic [W-1:0] wr_op(input logic [AW-1:0] a, input logic [31:0] d);
    return {2'b01, a, d};
  endfunction
  function automatic logic [W-1:0] rd_op(input logic [AW-1:0] a);
    return {2'b10, a, 32'h0};
  endfunction

  always @(negedge clk) begin
    logic wr, rd;
    logic [W-1:0] got, e;
    if (rst_i) begin
      exp_q.delete(); res_q.delete();
      occ = 0; tx_first = 1'b1; tx_len = 0;
      prev_strobe = 1'b0; prev_valid = 1'b0; chk_rst = 1'b1;
      frames_read = 0; frames_hs = 0;
    end else begin
      if (chk_rst) begin
        chk("rst_s_ready", s_ready_o, 1'b1);
        chk("rst_strobes", {edwr_l_o, edwr_h_o, sedrd_o}, 3'b111);
        chk("rst_adr_src", {pr_adr_o, src_o}, '0);
        chk("rst_res", {res_valid_o, res_crc_o, res_count_o}, '0);
        chk_rst = 1'b0;
      end
      // Ready follows FIFO fill level only.
      chk("s_ready", s_ready_o, occ < DEPTH);

      wr = !edwr_l_o || !edwr_h_o;
      rd = !sedrd_o;
      if (prev_strobe) chk("gap_cycle", {wr, rd, pr_adr_o, src_o}, '0);
      if (wr || rd) begin
        chk("no_bus_in_res", res_valid_o, 1'b0);
        chk("access_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e   = exp_q.pop_front();
          got = {rd, wr, pr_adr_o, src_o};
          chk("bus_op", got, e);
          if (wr && pr_adr_o == A_DATA) begin
            chk("data_strobes", {edwr_l_o, edwr_h_o}, 2'b00);
            occ--;
            dw_cnt++;
          end
          if (wr && pr_adr_o == A_CONF) begin
            last_conf = src_o;
            conf_cyc  = cyc;
            if (fs_arm && fs_acc >= 0) begin
              chk("first_strobe_latency", cyc - fs_acc, 1);
              fs_arm = 1'b0;
            end
          end
          if (rd && pr_adr_o == (CNT_EN ? A_CNT : A_OUT)) frames_read++;
        end
      end else begin
        chk("idle_bus", {pr_adr_o, src_o}, '0);
      end
      prev_strobe = wr || rd;

      // Results: compared against the expected frame every cycle they are offered.
      if (res_valid_o) begin
        if (!prev_valid) begin
          chk("reads_before_res", frames_read > frames_hs, 1'b1);
          if (lat_n > 0) chk("frame_latency", cyc - conf_cyc, 4 + 2 * lat_n + (CNT_EN ? 2 : 0));
        end
        chk("res_expected", res_q.size() > 0, 1'b1);
        if (res_q.size() > 0) begin
          chk("res_crc", res_crc_o, res_q[0][63:32]);
          chk("res_count", res_count_o, res_q[0][31:0]);
          if (res_ready_i) begin
            void'(res_q.pop_front());
            frames_hs++;
            last_crc = res_crc_o;
            last_cnt = res_count_o;
          end
        end
      end
      prev_valid = res_valid_o;

      // Accepted stream word: derive the bus accesses it must cause.
      if (s_valid_i && s_ready_o) begin
        if (tx_first) begin
          exp_q.push_back(wr_op(A_CONF, {30'b0, 1'b1, s_poly_i}));
          tx_len = 0;
          if (fs_arm && fs_acc < 0) fs_acc = cyc;
        end
        exp_q.push_back(wr_op(A_DATA, s_data_i));
        tx_len++;
        if (s_last_i) begin
          exp_q.push_back(rd_op(A_OUT));
          if (CNT_EN) exp_q.push_back(rd_op(A_CNT));
          res_q.push_back({CRC_V, CNT_EN ? 32'(tx_len) : 32'h0});
        end
        tx_first = s_last_i;
        occ++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_word(input logic [31:0] d, input logic l, input logic p);
    bit acc;
    int n;
    s_data_i = d; s_last_i = l; s_poly_i = p; s_valid_i = 1'b1;
    acc = 1'b0; n = 0;
    while (!acc && n < 500) begin
      @(negedge clk); acc = s_ready_o;
      @(posedge clk); #1; n++;
    end
    s_valid_i = 1'b0;
    if (!acc) chk("send_timeout", acc, 1'b1);
  endtask

  task automatic send_frame(input int n, input logic p, input int gapmax);
    for (int i = 0; i < n; i++) begin
      send_word($urandom, i == n - 1, p);
      if (gapmax > 0) step($urandom_range(0, gapmax));
    end
  endtask

  task automatic wait_valid(input int bound);
    int n;
    n = 0;
    while (!res_valid_o && n < bound) begin step(1); n++; end
    if (!res_valid_o) chk("wait_valid_timeout", res_valid_o, 1'b1);
  endtask

  task automatic drain(input int bound);
    int n;
    bit busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < bound) begin
      step(1); n++;
      busy = (exp_q.size() != 0) || (res_q.size() != 0) || res_valid_o;
    end
    if (busy) chk("drain_timeout", busy, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] w4[6];
  initial begin
    int idx;
    int base;
    bit acc;
    rst_i = 1'b1;
    step(3);
    rst_i = 1'b0;
    step(2);

    // Frame of four fixed words, poly 0, back-to-back, with latency checks.
    rr_val = 1'b1; lat_n = 4; fs_arm = 1'b1; fs_acc = -1;
    send_word(32'h1f1f1f1f, 1'b0, 1'b0);
    send_word(32'h00000000, 1'b0, 1'b0);
    send_word(32'h11111111, 1'b0, 1'b0);
    send_word(32'hffffffff, 1'b1, 1'b0);
    drain(200);
    lat_n = 0;
    chk("t1_conf", last_conf, 32'h2);
    chk("t1_crc", last_crc, 32'hDEADBEEF);
    chk("t1_count", last_cnt, CNT_EN ? 32'd4 : 32'd0);

    // Same frame with poly 1; hold the result until ready rises.
    rr_val = 1'b0;
    base = frames_hs;
    send_word(32'h1f1f1f1f, 1'b0, 1'b1);
    send_word(32'h00000000, 1'b0, 1'b1);
    send_word(32'h11111111, 1'b0, 1'b1);
    send_word(32'hffffffff, 1'b1, 1'b1);
    wait_valid(200);
    step(3);
    rr_val = 1'b1;
    drain(200);
    chk("t2_conf", last_conf, 32'h3);
    chk("t2_handshake", frames_hs - base, 1);

    // Single-word frame.
    lat_n = 1;
    send_word(32'h0, 1'b1, 1'b0);
    drain(200);
    lat_n = 0;
    chk("t3_count", last_cnt, CNT_EN ? 32'd1 : 32'd0);

    // Result stalled for 20 cycles while six more words are offered.
    rr_val = 1'b0;
    send_frame(2, 1'b0, 0);
    wait_valid(200);
    for (int i = 0; i < 6; i++) w4[i] = $urandom;
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      if (idx < 6) begin
        s_data_i = w4[idx]; s_last_i = (idx == 5); s_poly_i = 1'b1; s_valid_i = 1'b1;
      end else s_valid_i = 1'b0;
      @(negedge clk); acc = s_valid_i && s_ready_o;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    s_valid_i = 1'b0;
    chk("t4_accepted_while_stalled", idx, 4);
    rr_val = 1'b1;
    while (idx < 6) begin send_word(w4[idx], idx == 5, 1'b1); idx++; end
    drain(300);
    chk("t4_count", last_cnt, CNT_EN ? 32'd6 : 32'd0);

    // Reset after the second data write of a frame, then a fresh 2-word frame.
    base = dw_cnt;
    send_frame(4, 1'b0, 0);
    idx = 0;
    while (dw_cnt < base + 2 && idx < 100) begin step(1); idx++; end
    chk("t5_reached_2nd_write", dw_cnt >= base + 2, 1'b1);
    rst_i = 1'b1;
    step(1);
    rst_i = 1'b0;
    step(1);
    send_frame(2, 1'b1, 0);
    drain(200);
    chk("t5_conf", last_conf, 32'h3);
    chk("t5_count", last_cnt, CNT_EN ? 32'd2 : 32'd0);

    // Randomized frames, gaps and result back-pressure.
    rr_rand = 1'b1;
    for (int f = 0; f < 25; f++) begin
      send_frame($urandom_range(1, 6), 1'($urandom_range(0, 1)), 3);
      step($urandom_range(0, 4));
    end
    rr_rand = 1'b0;
    rr_val  = 1'b1;
    step(2);
    drain(2000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
